// File: rtl/mem_stage_mc_if.sv
// mem_stage_mc_if: the bundle of signals between EXE, the data RAM response,
// the MEM stage and WB.
//
// Parameters: DATA_W (32 or 64), PC_W, RF_AW.
// Modports:
//   slave  - the MEM stage itself (takes EXE fields, RAM response and
//            WB_allow_in; drives MEM_allow_in and the MEM_* outputs)
//   master - the surrounding pipeline / bench (the opposite directions)
// With MEM_FWD_EN defined, the forwarding outputs MEM_fwd_valid,
// MEM_fwd_waddr, MEM_fwd_data and MEM_fwd_stall are added.
//
// Handshake: an instruction moves EXE->MEM on a cycle where
// EXE_to_MEM_valid & MEM_allow_in, and MEM->WB on a cycle where
// MEM_to_WB_valid & WB_allow_in. Both are sampled on the rising clock edge.
interface mem_stage_mc_if #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int RF_AW  = 5
);
  logic              EXE_to_MEM_valid;
  logic              MEM_allow_in;
  logic [PC_W-1:0]   EXE_pc;
  logic [DATA_W-1:0] EXE_alu_res;
  logic [RF_AW-1:0]  EXE_rf_waddr;
  logic [1:0]        EXE_rf_wsel;
  logic              EXE_rf_wen;
  logic              EXE_is_load;
  logic [2:0]        EXE_load_type;
  logic              data_ram_data_ok;
  logic [DATA_W-1:0] data_ram_r_data;
  logic              WB_allow_in;
  logic              MEM_to_WB_valid;
  logic [PC_W-1:0]   MEM_pc;
  logic [DATA_W-1:0] MEM_alu_res;
  logic [DATA_W-1:0] MEM_load_data;
  logic [RF_AW-1:0]  MEM_rf_waddr;
  logic [1:0]        MEM_rf_wsel;
  logic              MEM_rf_wen;
`ifdef MEM_FWD_EN
  logic              MEM_fwd_valid;
  logic [RF_AW-1:0]  MEM_fwd_waddr;
  logic [DATA_W-1:0] MEM_fwd_data;
  logic              MEM_fwd_stall;
`endif

  modport slave (
`ifdef MEM_FWD_EN
    output MEM_fwd_valid, MEM_fwd_waddr, MEM_fwd_data, MEM_fwd_stall,
`endif
    input  EXE_to_MEM_valid, EXE_pc, EXE_alu_res, EXE_rf_waddr, EXE_rf_wsel,
           EXE_rf_wen, EXE_is_load, EXE_load_type, data_ram_data_ok,
           data_ram_r_data, WB_allow_in,
    output MEM_allow_in, MEM_to_WB_valid, MEM_pc, MEM_alu_res, MEM_load_data,
           MEM_rf_waddr, MEM_rf_wsel, MEM_rf_wen
  );

  modport master (
`ifdef MEM_FWD_EN
    input  MEM_fwd_valid, MEM_fwd_waddr, MEM_fwd_data, MEM_fwd_stall,
`endif
    output EXE_to_MEM_valid, EXE_pc, EXE_alu_res, EXE_rf_waddr, EXE_rf_wsel,
           EXE_rf_wen, EXE_is_load, EXE_load_type, data_ram_data_ok,
           data_ram_r_data, WB_allow_in,
    input  MEM_allow_in, MEM_to_WB_valid, MEM_pc, MEM_alu_res, MEM_load_data,
           MEM_rf_waddr, MEM_rf_wsel, MEM_rf_wen
  );
endinterface

// File: rtl/mem_stage_mc.sv
// mem_stage_mc: MEM pipeline stage with a variable-latency data-RAM load
// response. Holds one instruction, waits for data_ok on loads, buffers the
// load data while WB stalls, and performs lane selection plus sign/zero
// extension before WB.
//
// Parameters: DATA_W (32 or 64), PC_W, RF_AW.
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   bus          mem_stage_mc_if.slave (EXE fields, RAM response, WB
//                handshake and the registered MEM_* outputs)
//   dbg_state_o  current FSM state (0 EMPTY, 1 NONLOAD, 2 WAIT, 3 HOLD)
// Optional feature: define MEM_FWD_EN to add the MEM_fwd_* forwarding
// outputs; without it those ports and their logic are absent.
//
// Handshake: valid/allow_in/ready_go. MEM accepts from EXE when
// EXE_to_MEM_valid & MEM_allow_in; it hands to WB when
// MEM_to_WB_valid & WB_allow_in. A handoff and a new capture may happen in
// the same cycle, so back-to-back instructions flow without a bubble.
module mem_stage_mc #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int RF_AW  = 5
) (
  input  logic             clk,
  input  logic             reset,
  mem_stage_mc_if.slave    bus,
  output logic [1:0]       dbg_state_o
);
  localparam int OFF_W = $clog2(DATA_W / 8);

  // The state also encodes MEM_valid (!= EMPTY), is_load (WAIT/HOLD) and
  // buf_valid (HOLD).
  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_NONLOAD = 2'd1,
    S_WAIT    = 2'd2,
    S_HOLD    = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q;
  logic [DATA_W-1:0] alu_res_q;
  logic [RF_AW-1:0]  rf_waddr_q;
  logic [1:0]        rf_wsel_q;
  logic              rf_wen_q;
  logic [2:0]        load_type_q;
  logic [DATA_W-1:0] buf_q;

  logic mem_valid, is_load, data_ok_now, ready_go, allow_in, capture, handoff;

  assign mem_valid   = (state_q != S_EMPTY);
  assign is_load     = (state_q == S_WAIT) || (state_q == S_HOLD);
  // data_ok outside WAIT is ignored, which also drops stray responses that
  // arrive after a reset discarded the waiting load.
  assign data_ok_now = (state_q == S_WAIT) && bus.data_ram_data_ok;
  assign ready_go    = !is_load || data_ok_now || (state_q == S_HOLD);
  assign allow_in    = !mem_valid || (bus.WB_allow_in && ready_go);
  assign capture     = bus.EXE_to_MEM_valid && allow_in;
  assign handoff     = mem_valid && ready_go && bus.WB_allow_in;

  always_comb begin
    state_d = state_q;
    if (capture) begin
      state_d = bus.EXE_is_load ? S_WAIT : S_NONLOAD;
    end else if (handoff) begin
      state_d = S_EMPTY;
    end else if (data_ok_now) begin
      // Data arrived but WB is stalled: park it in the buffer.
      state_d = S_HOLD;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_EMPTY;
      pc_q        <= '0;
      alu_res_q   <= '0;
      rf_waddr_q  <= '0;
      rf_wsel_q   <= '0;
      rf_wen_q    <= 1'b0;
      load_type_q <= '0;
      buf_q       <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        pc_q        <= bus.EXE_pc;
        alu_res_q   <= bus.EXE_alu_res;
        rf_waddr_q  <= bus.EXE_rf_waddr;
        rf_wsel_q   <= bus.EXE_rf_wsel;
        rf_wen_q    <= bus.EXE_rf_wen;
        load_type_q <= bus.EXE_load_type;
      end
      if (data_ok_now && !bus.WB_allow_in) begin
        buf_q <= bus.data_ram_r_data;
      end
    end
  end

  // Lane selection. Misaligned offsets are rounded down to the field size.
  logic [DATA_W-1:0] raw;
  logic [OFF_W-1:0]  off_b, off_h, off_w;
  logic [7:0]        field_b;
  logic [15:0]       field_h;
  logic [31:0]       field_w;
  logic [DATA_W-1:0] ext;

  assign raw     = (state_q == S_HOLD) ? buf_q : bus.data_ram_r_data;
  assign off_b   = alu_res_q[OFF_W-1:0];
  assign off_h   = off_b & ~OFF_W'(1);
  assign off_w   = off_b & ~OFF_W'(3);   // always 0 when DATA_W is 32
  assign field_b = 8'(raw >> {off_b, 3'b000});
  assign field_h = 16'(raw >> {off_h, 3'b000});
  assign field_w = 32'(raw >> {off_w, 3'b000});

  always_comb begin
    ext = raw;
    case (load_type_q)
      3'd0:    ext = DATA_W'($signed(field_b));
      3'd1:    ext = DATA_W'(field_b);
      3'd2:    ext = DATA_W'($signed(field_h));
      3'd3:    ext = DATA_W'(field_h);
      3'd4:    ext = DATA_W'($signed(field_w));
      3'd5:    ext = DATA_W'(field_w);      // full word when DATA_W is 32
      default: ext = raw;                   // LD: whole datapath word
    endcase
  end

  assign bus.MEM_allow_in    = allow_in;
  assign bus.MEM_to_WB_valid = mem_valid && ready_go;
  assign bus.MEM_pc          = pc_q;
  assign bus.MEM_alu_res     = alu_res_q;
  assign bus.MEM_load_data   = ext;
  assign bus.MEM_rf_waddr    = rf_waddr_q;
  assign bus.MEM_rf_wsel     = rf_wsel_q;
  assign bus.MEM_rf_wen      = rf_wen_q;
  assign dbg_state_o         = state_q;

`ifdef MEM_FWD_EN
  // A load forwards its extended data only once it is ready; until then ID
  // must interlock on MEM_fwd_stall.
  assign bus.MEM_fwd_valid = mem_valid && rf_wen_q;
  assign bus.MEM_fwd_waddr = rf_waddr_q;
  assign bus.MEM_fwd_data  = (is_load && ready_go) ? ext : alu_res_q;
  assign bus.MEM_fwd_stall = mem_valid && is_load && !ready_go;
`endif
endmodule

// File: doc/mem_stage_mc.md
Name: mem_stage_mc

Overview:
- Parametrised successor to the fixed-width, single-cycle MEM pipeline stage.
- Sits between EXE and WB. Holds one instruction and waits for a variable-latency data-RAM response on loads.
- Buffers load data while WB stalls. Performs byte/half/word(/double) lane selection and sign/zero extension before WB.
- Uses the standard valid/allow_in/ready_go handshake.

Parameters:
- DATA_W, 32, datapath width; legal values 32 or 64.
- PC_W, 32, PC width.
- RF_AW, 5, register-file address width.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- EXE_to_MEM_valid  in  1  EXE holds a valid instruction
- MEM_allow_in  out  1  MEM can accept this cycle
- EXE_pc  in  PC_W  instruction PC
- EXE_alu_res  in  DATA_W  ALU result / load address
- EXE_rf_waddr  in  RF_AW  destination register
- EXE_rf_wsel  in  2  WB write-data select
- EXE_rf_wen  in  1  register write enable
- EXE_is_load  in  1  instruction is a load (RAM request already issued by EXE)
- EXE_load_type  in  3  0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 LWU, 6 LD
- data_ram_data_ok  in  1  read data valid this cycle
- data_ram_r_data  in  DATA_W  raw read word
- WB_allow_in  in  1  WB can accept
- MEM_to_WB_valid  out  1  MEM output valid
- MEM_pc  out  PC_W  registered PC
- MEM_alu_res  out  DATA_W  registered ALU result
- MEM_load_data  out  DATA_W  extended load data
- MEM_rf_waddr  out  RF_AW  registered destination
- MEM_rf_wsel  out  2  registered select
- MEM_rf_wen  out  1  registered write enable

Behaviour:
- Reset (reset=0, async):
  - MEM_valid=0, FSM=EMPTY, data buffer cleared.
  - All registered outputs are 0. MEM_allow_in=1. MEM_to_WB_valid=0.
- Capture: on EXE_to_MEM_valid & MEM_allow_in, latch all EXE_* fields and set MEM_valid=1.
- MEM_allow_in = ~MEM_valid | (WB_allow_in & MEM_ready_go). This is combinational.
- MEM_ready_go = ~is_load | data_ok_now | buf_valid.
- MEM_to_WB_valid = MEM_valid & MEM_ready_go.
- FSM:
  - EMPTY -> NONLOAD or WAIT on capture, depending on is_load.
  - NONLOAD: ready immediately (latency 1 cycle, as before).
  - WAIT: stays until data_ok.
    - On data_ok with WB_allow_in=1, raw data is extended and passed through combinationally; the stage empties or refills the same cycle.
    - On data_ok with WB_allow_in=0, raw data goes to the buffer (buf_valid=1) and the FSM moves to HOLD.
  - HOLD: MEM_load_data is taken from the buffer and held stable until WB_allow_in. Then buf_valid clears.
  - Any state: a handoff together with a new capture in the same cycle loads the new instruction. There is no bubble.
- data_ok handling:
  - Accepted only in WAIT.
  - data_ok in EMPTY, NONLOAD or HOLD is ignored; EXE guarantees this never happens.
  - The earliest legal data_ok is the cycle after capture.
- Extension:
  - Lane offset = alu_res[log2(DATA_W/8)-1:0].
  - Selected field is sign-extended for LB/LH/LW and zero-extended for LBU/LHU/LWU.
  - LW/LWU/LD with DATA_W=32: LW returns the full word; LWU and LD behave as LW.
  - A misaligned offset is not checked; the field is taken from lane (offset & ~(size-1)).
- Outputs are registered fields plus extension logic. With WB stalled, outputs are held stable for the whole stall.
- Reset asserted mid-WAIT or mid-HOLD discards the instruction and the buffer immediately. A later stray data_ok is ignored.

Optional Feature:
- Macro MEM_FWD_EN.
- When defined, extra outputs are added:
  - MEM_fwd_valid = MEM_valid & MEM_rf_wen.
  - MEM_fwd_waddr.
  - MEM_fwd_data: extended load data when ready, else alu_res.
  - MEM_fwd_stall = MEM_valid & is_load & ~MEM_ready_go. ID uses this to interlock.
- When undefined, these ports and their logic are absent; behaviour is otherwise identical.

Test Plan:
- Non-load, alu_res=0x1234, WB_allow_in=1 -> MEM_to_WB_valid=1 the cycle after capture, MEM_alu_res=0x1234, MEM_allow_in=1.
- LB, addr 0x1003, r_data=0x80FF_0000, data_ok 3 cycles after capture -> MEM_to_WB_valid=0 for 2 cycles, then 1 with MEM_load_data=0xFFFF_FF80.
- LHU, addr 0x2002, r_data=0xBEEF_1234, data_ok while WB_allow_in=0 for 4 cycles -> MEM_load_data=0x0000_BEEF held stable in HOLD, MEM_allow_in=0, then one handoff when WB frees.
- Back-to-back non-load then LW with WB_allow_in=1 -> no bubble; second capture in the cycle of the first handoff.
- reset=0 asynchronously during WAIT, then data_ok pulse after release -> MEM_to_WB_valid stays 0, no write reaches WB.
- MEM_FWD_EN, LW in WAIT -> MEM_fwd_stall=1 until data_ok; then MEM_fwd_data equals the loaded word.
